bite_timer: RTL and testbench

BITE_TIMER -- requirements
Module: bite_timer

---
 rtl/bite_timer.sv | 142 ++++++++++++++
 tb/tb_bite_timer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bite_timer.sv
// Fishing-game bite timer: after a cast, waits a random delay in ms, then opens
// a bite window during which a player strike counts as a catch.
module bite_timer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int MIN_MS      = 500,
  parameter int RAND_BITS   = 11,
  parameter int WINDOW_MS   = 750
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic        Cancel,
  input  logic        Catch,
  input  logic [15:0] Rand,
  output logic        LFSR_Run,
  output logic        Busy,
  output logic        Bite,
  output logic        Caught,
  output logic        Missed
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BITE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_q, ms_d;
  logic          caught_q, caught_d;
  logic          missed_q, missed_d;
  logic          bite_q, busy_q, run_q;
  logic          tick;
  logic [15:0]   delayMs;

  // Only the low RAND_BITS of the LFSR feed the delay; the rest is intentionally dropped.
  logic randHighUnused;
  assign randHighUnused = ^Rand;

  assign delayMs = 16'(MIN_MS) + 16'(Rand[RAND_BITS-1:0]);
  assign tick    = (presc_q == PMAX);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    ms_d     = ms_q;
    caught_d = 1'b0;
    missed_d = 1'b0;
    if (Cancel) begin
      state_d = S_IDLE;
      presc_d = '0;
      ms_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (Start) begin
            state_d = S_WAIT;
            ms_d    = delayMs;
            presc_d = '0;
          end
        end
        S_WAIT: begin
          if (Catch) begin
            missed_d = 1'b1;
            state_d  = S_IDLE;
            presc_d  = '0;
            ms_d     = '0;
          end else if (tick) begin
            presc_d = '0;
            // The ms counter reaching zero opens the window and reloads it.
            if (ms_q <= 16'd1) begin
              state_d = S_BITE;
              ms_d    = 16'(WINDOW_MS);
            end else begin
              ms_d = ms_q - 16'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        S_BITE: begin
          if (Catch) begin
            caught_d = 1'b1;
            state_d  = S_IDLE;
            presc_d  = '0;
            ms_d     = '0;
          end else if (tick) begin
            presc_d = '0;
            if (ms_q <= 16'd1) begin
              missed_d = 1'b1;
              state_d  = S_IDLE;
              ms_d     = '0;
            end else begin
              ms_d = ms_q - 16'd1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          presc_d = '0;
          ms_d    = '0;
        end
      endcase
    end
  end

  // Status outputs are decoded from the next state so they are true flops.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      ms_q     <= '0;
      caught_q <= 1'b0;
      missed_q <= 1'b0;
      bite_q   <= 1'b0;
      busy_q   <= 1'b0;
      run_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_q     <= ms_d;
      caught_q <= caught_d;
      missed_q <= missed_d;
      bite_q   <= (state_d == S_BITE);
      busy_q   <= (state_d != S_IDLE);
      run_q    <= (state_d == S_IDLE);
    end
  end

  assign LFSR_Run = run_q;
  assign Busy     = busy_q;
  assign Bite     = bite_q;
  assign Caught   = caught_q;
  assign Missed   = missed_q;

endmodule

// File: tb/tb_bite_timer.sv
// Bench for bite_timer: directed vector table, hand sequences for window timing
// and reset corners, then random traffic against a cycle-count reference model.
module tb_bite_timer;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0, Cancel = 1'b0, Catch = 1'b0;
  logic [15:0] Rand = 16'h0;
  logic        LFSR_Run, Busy, Bite, Caught, Missed;

  int checks = 0;
  int failures = 0;

  // Model: 0 idle, 1 waiting, 2 bite window; mLeft counts edges left in the phase.
  int   mMode = 0;
  int   mLeft = 0;
  logic mCaught = 1'b0, mMissed = 1'b0;

  typedef struct {
    logic        s, c, k;
    logic [15:0] r;
    logic [3:0]  exp;
  } vec_t;
  vec_t vecs[9];

  bite_timer #(.CLKS_PER_MS(4), .MIN_MS(2), .RAND_BITS(3), .WINDOW_MS(3)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Cancel(Cancel), .Catch(Catch), .Rand(Rand),
    .LFSR_Run(LFSR_Run), .Busy(Busy), .Bite(Bite), .Caught(Caught), .Missed(Missed)
  );

  always #5 CLK = ~CLK;

  task automatic modelStep(input logic s, input logic c, input logic k, input logic [15:0] r);
    mCaught = 1'b0;
    mMissed = 1'b0;
    if (c) mMode = 0;
    else if (mMode == 0) begin
      if (s) begin mMode = 1; mLeft = (2 + int'(r[2:0])) * 4; end
    end else if (mMode == 1) begin
      if (k) begin mMissed = 1'b1; mMode = 0; end
      else begin
        mLeft--;
        if (mLeft == 0) begin mMode = 2; mLeft = 12; end
      end
    end else begin
      if (k) begin mCaught = 1'b1; mMode = 0; end
      else begin
        mLeft--;
        if (mLeft == 0) begin mMissed = 1'b1; mMode = 0; end
      end
    end
  endtask

  task automatic applyStimulus(input logic s, input logic c, input logic k, input logic [15:0] r);
    Start = s; Cancel = c; Catch = k; Rand = r;
    @(posedge CLK);
    #1;
    modelStep(s, c, k, r);
    Start = 1'b0; Cancel = 1'b0; Catch = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    logic [4:0] exp, act;
    exp = {mMode != 0, mMode == 2, mCaught, mMissed, mMode == 0};
    act = {Busy, Bite, Caught, Missed, LFSR_Run};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: {Busy,Bite,Caught,Missed,Run} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic c, input logic k, input logic [15:0] r, input string name);
    applyStimulus(s, c, k, r);
    checkOutput(name);
  endtask

  // Steps until Bite rises; n is edges counted including the first step, or limit+1 on timeout.
  task automatic waitBite(input int limit, output int n);
    n = limit + 1;
    for (int i = 1; i <= limit; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'hFFFF, "waitBite");
      if (Bite) begin n = i; break; end
    end
  endtask

  task automatic resetMid(input string name);
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({Busy, Bite, Caught, Missed, LFSR_Run} !== 5'b00001) begin
      failures++;
      $display("[TB] FAIL %s: outputs got %b expected 00001", name, {Busy, Bite, Caught, Missed, LFSR_Run});
    end
    mMode = 0; mCaught = 1'b0; mMissed = 1'b0;
    #2 RST = 1'b1;
  endtask

  initial begin
    int n, hi;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h9968, 4'b1000};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'b1000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 16'h0007, 4'b1000};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'b0001};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 16'h0000, 4'b0000};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 16'h0000, 4'b1000};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000};

    #12;
    checkOutput("power-on reset");
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Directed table: early strike, idle catch, cancel priority.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].s, vecs[i].c, vecs[i].k, vecs[i].r);
      checks++;
      if ({Busy, Bite, Caught, Missed} !== vecs[i].exp || LFSR_Run !== ~vecs[i].exp[3]) begin
        failures++;
        $display("[TB] FAIL vec%0d: {Busy,Bite,Caught,Missed,Run} got %b expected %b", i,
                 {Busy, Bite, Caught, Missed, LFSR_Run}, {vecs[i].exp, ~vecs[i].exp[3]});
      end
      checkOutput("vec model");
    end

    // D=9: bite 36 edges after Start, catch on 5th bite cycle.
    step(1'b1, 1'b0, 1'b0, 16'h225F, "start D9");
    waitBite(100, n);
    checkVal("D9 bite latency", n, 36);
    repeat (4) step(1'b0, 1'b0, 1'b0, 16'h1234, "D9 window");
    step(1'b0, 1'b0, 1'b1, 16'h1234, "D9 catch");
    checkVal("D9 caught pulse", int'(Caught), 1);
    step(1'b0, 1'b0, 0, 16'h0, "D9 after catch");

    // D=2, no catch: window length and expiry.
    step(1'b1, 1'b0, 1'b0, 16'h9968, "start D2");
    waitBite(100, n);
    checkVal("D2 bite latency", n, 8);
    hi = 1;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b0, 1'b0, 16'h0, "D2 window");
      if (!Bite) break;
      hi++;
    end
    checkVal("D2 window length", hi, 12);
    checkVal("D2 expiry missed", int'(Missed), 1);
    step(1'b0, 1'b0, 1'b0, 16'h0, "D2 after expiry");

    // Second Start while busy must not retime the cast.
    step(1'b1, 1'b0, 1'b0, 16'h9968, "start busy test");
    step(1'b0, 1'b0, 1'b0, 16'h0, "busy test wait");
    step(1'b1, 1'b0, 1'b0, 16'h0007, "ignored start");
    waitBite(100, n);
    checkVal("restart ignored latency", n + 2, 8);
    repeat (12) step(1'b0, 1'b0, 1'b0, 16'h0, "busy test expire");

    // Cancel and Catch together in the window.
    step(1'b1, 1'b0, 1'b0, 16'h0000, "start cancel test");
    waitBite(100, n);
    repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0, "cancel test window");
    step(1'b0, 1'b1, 1'b1, 16'h0, "cancel+catch");
    checkVal("cancel+catch pulses", int'({Caught, Missed, Busy}), 0);

    // Catch on the final window cycle beats expiry.
    step(1'b1, 1'b0, 1'b0, 16'h0000, "start last cycle");
    waitBite(100, n);
    repeat (11) step(1'b0, 1'b0, 1'b0, 16'h0, "last cycle window");
    step(1'b0, 1'b0, 1'b1, 16'h0, "last cycle catch");
    checkVal("last cycle caught/missed", int'({Caught, Missed}), 2);

    // Reset mid-WAIT, then a clean cast with D=5.
    step(1'b1, 1'b0, 1'b0, 16'h225F, "start pre-reset");
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0, "pre-reset wait");
    resetMid("reset mid-wait");
    step(1'b1, 1'b0, 1'b0, 16'h0003, "start D5");
    waitBite(100, n);
    checkVal("D5 bite latency", n, 20);
    repeat (2) step(1'b0, 1'b0, 1'b0, 16'h0, "D5 window");
    resetMid("reset mid-bite");
    step(1'b0, 1'b0, 1'b0, 16'h0, "after reset");

    // Random traffic against the model, with an occasional async reset.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 14) == 0,
           16'($urandom), "random");
      if (i % 500 == 499) resetMid("random reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
